gates_sweep_checker: RTL and testbench
======================================

Name: gates_sweep_checker

Overview:
- Stimulus and check stage that sits directly in front of and behind the 4-bit `gates` block.
- It drives operand `a` through every value 0..2^WIDTH-1 with `b` held, waits a settle interval, then samples `y1..y5`.
- Each sample is compared against the golden function: y1=a&b, y2=a|b, y3=a^b, y4=~(a&b), y5=~(a|b).
- It reports an error count, the first failing operand and a sticky per-output mismatch mask. This replaces hand-written delay-based sweeps with a clocked, self-checking sequence.

Parameters:
- WIDTH, 4, operand and result width.
- SETTLE, 2, cycles `a`/`b` are held before `y1..y5` are sampled; legal range is 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  reset.
- start  in  1  request a sweep; sampled only in IDLE.
- b_val  in  WIDTH  `b` operand; latched on accepted start and held for the whole sweep.
- a  out  WIDTH  operand to `gates`.
- b  out  WIDTH  operand to `gates`.
- y1..y5  in  WIDTH each  results from `gates`.
- busy  out  1  high in SETTLE and SAMPLE.
- done  out  1  one-cycle pulse at the end of a sweep.
- err_count  out  WIDTH+1  number of sampled points with any mismatch.
- first_err_a  out  WIDTH  value of `a` at the first failing point.
- first_err_valid  out  1  `first_err_a` is meaningful.
- mismatch_mask  out  5  sticky flags; bit i-1 set if y<i> ever mismatched.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state = IDLE
  - a = 0, b = 0
  - busy = 0, done = 0
  - err_count = 0, first_err_a = 0, first_err_valid = 0, mismatch_mask = 0
  - settle counter = 0
- Reset mid-sweep: everything returns to the reset values on the next edge. There is no partial-result retention.
- All outputs are registered.
- States:
  - IDLE:
    - If start=1: b <= b_val, a <= 0, clear err_count, first_err_a, first_err_valid and mismatch_mask; counter <= 0; go to SETTLE.
    - Otherwise: hold all outputs, including the last sweep's results.
  - SETTLE:
    - The counter increments each cycle.
    - When counter == SETTLE-1, go to SAMPLE.
    - `a`/`b` are stable throughout.
  - SAMPLE (one cycle): compute the expected results from the current `a`/`b`, then:
    - mism[4:0] = per-output inequality of y1..y5 against expected.
    - If mism != 0:
      - err_count <= err_count+1; this saturates at all-ones, but it is unreachable for legal WIDTH.
      - mismatch_mask <= mismatch_mask | mism.
      - If first_err_valid == 0: first_err_a <= a and first_err_valid <= 1.
    - If a == 2^WIDTH-1: go to DONE. `a` is held, with no wrap.
    - Otherwise: a <= a+1, counter <= 0, go to SETTLE.
  - DONE: done = 1 for exactly this one cycle, then IDLE.
- busy = 1 exactly in SETTLE and SAMPLE. done and busy are never high together.
- Timing:
  - Each operand point occupies SETTLE+1 cycles.
  - done is high in the cycle following the 2^WIDTH*(SETTLE+1)-th rising edge after the edge that accepted start. With defaults that is 48 edges.
- start while busy or in DONE is ignored; there is no queuing.
- A new start may be accepted in the IDLE cycle immediately after DONE.
- start held continuously produces back-to-back sweeps separated by the DONE and IDLE cycles.
- Results are stable from DONE until the next accepted start or reset.
- Expected-value arithmetic is bitwise at WIDTH bits; inversions are truncated to WIDTH.

Test Plan:
- Correct `gates` connected, b_val=4'b1111, one start pulse:
  - a steps 0..15, each value held 3 cycles.
  - done pulses at edge 48.
  - err_count=0, first_err_valid=0, mismatch_mask=5'b00000.
- Fault model y3=a|b, b_val=4'b1111:
  - err_count=15, first_err_a=4'b0001, first_err_valid=1, mismatch_mask=5'b00100.
- Fault model y4 stuck 4'b0000, b_val=4'b0000:
  - err_count=16, first_err_a=0, mismatch_mask=5'b01000.
- start held high for 60 cycles:
  - The second start is ignored during busy and accepted in the IDLE cycle after DONE.
  - Exactly one done in the first 50 edges.
  - Results are cleared when the second sweep begins.
- Reset asserted for one cycle while a=4'd7 during a faulty sweep:
  - Next cycle: state IDLE, a=0, b=0, busy=0, all result outputs 0.
  - No done pulse.
- SETTLE=1 build, correct `gates`, b_val=4'b1010:
  - done at edge 32, err_count=0, each a value held 2 cycles.

Source files
------------

// File: rtl/gates_sweep_checker.sv
// Clocked self-checking sweep for the 4-bit gates block: steps a through every value
// with b held, waits SETTLE cycles, then compares y1..y5 against the golden functions.
module gates_sweep_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] b_val,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] y1,
    input  logic [WIDTH-1:0] y2,
    input  logic [WIDTH-1:0] y3,
    input  logic [WIDTH-1:0] y4,
    input  logic [WIDTH-1:0] y5,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   err_count,
    output logic [WIDTH-1:0] first_err_a,
    output logic             first_err_valid,
    output logic [4:0]       mismatch_mask
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t     state, state_n;
    logic [3:0] cnt;
    logic [4:0] mism;
    logic       a_last;

    assign a_last = (a == {WIDTH{1'b1}});

    // Inversions compare at WIDTH bits, so ~ is truncated by the operand width.
    always_comb begin
        mism    = '0;
        mism[0] = (y1 != (a & b));
        mism[1] = (y2 != (a | b));
        mism[2] = (y3 != (a ^ b));
        mism[3] = (y4 != ~(a & b));
        mism[4] = (y5 != ~(a | b));
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start) state_n = S_SETTLE;
            S_SETTLE: if (cnt == 4'(SETTLE - 1)) state_n = S_SAMPLE;
            S_SAMPLE: state_n = a_last ? S_DONE : S_SETTLE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a               <= '0;
            b               <= '0;
            cnt             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_count       <= '0;
            first_err_a     <= '0;
            first_err_valid <= 1'b0;
            mismatch_mask   <= '0;
        end else begin
            // Status flags follow the next state so they stay registered yet aligned.
            busy <= (state_n == S_SETTLE) || (state_n == S_SAMPLE);
            done <= (state_n == S_DONE);
            case (state)
                S_IDLE: if (start) begin
                    b               <= b_val;
                    a               <= '0;
                    cnt             <= '0;
                    err_count       <= '0;
                    first_err_a     <= '0;
                    first_err_valid <= 1'b0;
                    mismatch_mask   <= '0;
                end
                S_SETTLE: cnt <= cnt + 4'd1;
                S_SAMPLE: begin
                    if (|mism) begin
                        if (err_count != {(WIDTH+1){1'b1}}) err_count <= err_count + 1'b1;
                        mismatch_mask <= mismatch_mask | mism;
                        if (!first_err_valid) begin
                            first_err_a     <= a;
                            first_err_valid <= 1'b1;
                        end
                    end
                    if (!a_last) begin
                        a   <= a + 1'b1;
                        cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gates_sweep_checker.sv
// Scoreboarded bench: a behavioural gates model (with selectable faults) feeds two checkers
// (SETTLE=2 and SETTLE=1); expected sweep summaries are queued at start and popped on done.
module tb_gates_sweep_checker;
    localparam int W = 4;

    typedef struct {
        int           errs;
        logic [W-1:0] first;
        bit           fv;
        logic [4:0]   mask;
        int           cycles;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   start;
    logic [W-1:0] b_val [2];
    logic [W-1:0] a [2], b [2], y1 [2], y2 [2], y3 [2], y4 [2], y5 [2];
    logic         busy [2], done [2], fev [2];
    logic [W:0]   errc [2];
    logic [W-1:0] fea [2];
    logic [4:0]   mm [2];
    int           mode [2];
    logic [W-1:0] kval [2];
    exp_t         q [2][$];
    int           done_cnt [2];
    int           checks = 0, passes = 0;

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [W-1:0] golden(int i, logic [W-1:0] av, logic [W-1:0] bv);
        logic [W-1:0] r;
        case (i)
            1: r = av & bv;
            2: r = av | bv;
            3: r = av ^ bv;
            4: r = ~(av & bv);
            default: r = ~(av | bv);
        endcase
        return r;
    endfunction

    // Modes: 0 correct, 1 y3=a|b, 2 y4 stuck 0, 3 y1/y5 bit0 flipped at a==k, 4 y2=a&b
    function automatic logic [W-1:0] gate(int m, int i, logic [W-1:0] av, logic [W-1:0] bv,
                                          logic [W-1:0] k);
        logic [W-1:0] r;
        r = golden(i, av, bv);
        if (m == 1 && i == 3) r = av | bv;
        if (m == 2 && i == 4) r = '0;
        if (m == 3 && av == k && (i == 1 || i == 5)) r = r ^ 1;
        if (m == 4 && i == 2) r = av & bv;
        return r;
    endfunction

    function automatic exp_t model(int m, logic [W-1:0] bv, logic [W-1:0] k, int set);
        exp_t e;
        logic [4:0] mi;
        e.errs = 0; e.first = '0; e.fv = 0; e.mask = '0;
        e.cycles = (1 << W) * (set + 1);
        for (int av = 0; av < (1 << W); av++) begin
            mi = '0;
            for (int i = 1; i <= 5; i++)
                if (gate(m, i, av[W-1:0], bv, k) != golden(i, av[W-1:0], bv)) mi[i-1] = 1'b1;
            if (mi != 0) begin
                e.errs++;
                e.mask |= mi;
                if (!e.fv) begin e.fv = 1; e.first = av[W-1:0]; end
            end
        end
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int SET = (g == 0) ? 2 : 1;

        assign y1[g] = gate(mode[g], 1, a[g], b[g], kval[g]);
        assign y2[g] = gate(mode[g], 2, a[g], b[g], kval[g]);
        assign y3[g] = gate(mode[g], 3, a[g], b[g], kval[g]);
        assign y4[g] = gate(mode[g], 4, a[g], b[g], kval[g]);
        assign y5[g] = gate(mode[g], 5, a[g], b[g], kval[g]);

        gates_sweep_checker #(.WIDTH(W), .SETTLE(SET)) dut (
            .clk(clk), .reset(reset), .start(start[g]), .b_val(b_val[g]),
            .a(a[g]), .b(b[g]),
            .y1(y1[g]), .y2(y2[g]), .y3(y3[g]), .y4(y4[g]), .y5(y5[g]),
            .busy(busy[g]), .done(done[g]), .err_count(errc[g]),
            .first_err_a(fea[g]), .first_err_valid(fev[g]), .mismatch_mask(mm[g])
        );

        int           bcnt = 0, run = 0;
        logic [W-1:0] prev = '0;
        exp_t         e;

        always @(negedge clk) begin
            if (reset) begin
                bcnt = 0; run = 0;
            end else begin
                if (busy[g] && done[g]) chk("busy_and_done", 1, 0);
                if (busy[g]) begin
                    if (bcnt == 0) begin
                        chk("a_first", int'(a[g]), 0);
                        prev = a[g]; run = 1;
                    end else if (a[g] == prev) run++;
                    else begin
                        chk("a_hold", run, SET + 1);
                        chk("a_step", int'(a[g]), int'(prev) + 1);
                        prev = a[g]; run = 1;
                    end
                    bcnt++;
                end
                if (done[g]) begin
                    done_cnt[g]++;
                    chk("a_hold_last", run, SET + 1);
                    if (q[g].size() == 0) chk("unexpected_done", 1, 0);
                    else begin
                        e = q[g].pop_front();
                        chk("err_count", int'(errc[g]), e.errs);
                        chk("first_err_a", int'(fea[g]), int'(e.first));
                        chk("first_err_valid", int'(fev[g]), int'(e.fv));
                        chk("mismatch_mask", int'(mm[g]), int'(e.mask));
                        chk("sweep_cycles", bcnt, e.cycles);
                    end
                    bcnt = 0; run = 0;
                end
            end
        end
    end

    task automatic wait_done(int g, int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (done[g]) seen = 1;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic sweep(int g, int m, logic [W-1:0] bv, logic [W-1:0] k);
        @(posedge clk); #1;
        mode[g] = m; b_val[g] = bv; kval[g] = k;
        q[g].push_back(model(m, bv, k, (g == 0) ? 2 : 1));
        start[g] = 1'b1;
        @(posedge clk); #1;
        start[g] = 1'b0;
        wait_done(g, 200);
    endtask

    initial begin
        int dones50, done_i, dc;
        bit hit;
        reset = 1'b1; start = '0;
        for (int g = 0; g < 2; g++) begin
            b_val[g] = '0; mode[g] = 0; kval[g] = '0; done_cnt[g] = 0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_a", int'(a[0]), 0);            chk("rst_b", int'(b[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);      chk("rst_done", int'(done[0]), 0);
        chk("rst_errc", int'(errc[0]), 0);      chk("rst_fea", int'(fea[0]), 0);
        chk("rst_fev", int'(fev[0]), 0);        chk("rst_mask", int'(mm[0]), 0);

        sweep(0, 0, 4'b1111, '0);
        sweep(0, 1, 4'b1111, '0);
        sweep(0, 2, 4'b0000, '0);
        for (int r = 0; r < 5; r++)
            sweep(0, int'($urandom_range(0, 4)), W'($urandom), W'($urandom));

        // start held high: faulty first sweep, correct second, results must be cleared
        @(posedge clk); #1;
        mode[0] = 2; b_val[0] = 4'b0101;
        q[0].push_back(model(2, 4'b0101, '0, 2));
        q[0].push_back(model(0, 4'b0101, '0, 2));
        start[0] = 1'b1; dones50 = 0; done_i = -10;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (done[0]) begin
                mode[0] = 0; done_i = i;
                if (i <= 50) dones50++;
            end
            if (i == done_i + 2) begin
                chk("restart_busy", int'(busy[0]), 1);
                chk("restart_cleared", int'(errc[0]), 0);
            end
        end
        start[0] = 1'b0;
        chk("dones_in_50", dones50, 1);
        wait_done(0, 200);

        // reset mid-sweep at a==7 during a faulty sweep: no done may follow
        @(posedge clk); #1;
        mode[0] = 2; b_val[0] = 4'b0011; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0; hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk); #1;
            if (a[0] == 4'd7) hit = 1;
        end
        chk("reach_a7", int'(hit), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_a", int'(a[0]), 0);          chk("mid_b", int'(b[0]), 0);
        chk("mid_busy", int'(busy[0]), 0);    chk("mid_done", int'(done[0]), 0);
        chk("mid_errc", int'(errc[0]), 0);    chk("mid_fea", int'(fea[0]), 0);
        chk("mid_fev", int'(fev[0]), 0);      chk("mid_mask", int'(mm[0]), 0);
        dc = done_cnt[0];
        repeat (60) @(posedge clk);
        #1 chk("no_done_after_reset", done_cnt[0] - dc, 0);

        sweep(1, 0, 4'b1010, '0);
        sweep(1, int'($urandom_range(1, 4)), W'($urandom), W'($urandom));

        repeat (3) @(posedge clk);
        chk("queue0_empty", q[0].size(), 0);
        chk("queue1_empty", q[1].size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
